ii_frame_ctrl: RTL and testbench

Frame sequencer placed in front of the integral/squared-integral image generator. It takes an unframed pixel stream and forwards it to the generator's `din_*` port with row and frame end-of-transfer flags generated from internal column/row counters. It admits exactly one frame at a time: after the last pixel is accepted it blocks input until both the `ii` and `sii` output streams have delivered their end-of-frame beat, then reports completion.

---
 rtl/ii_frame_ctrl.sv | 108 ++++++++++
 tb/tb_ii_frame_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ii_frame_ctrl.sv
// ii_frame_ctrl: admits one pixel frame at a time into the integral-image generator,
// tags row/frame ends from local counters and waits for both output streams to finish.
module ii_frame_ctrl #(
   parameter int W_DATA = 8,
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int W_FCNT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic [W_FCNT-1:0] frame_cnt,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [W_DATA-1:0] pix_data,
   output logic              gen_valid,
   input  logic              gen_ready,
   output logic [W_DATA-1:0] gen_data,
   output logic [1:0]        gen_eot,
   input  logic              ii_mon_valid,
   input  logic              ii_mon_ready,
   input  logic [1:0]        ii_mon_eot,
   input  logic              sii_mon_valid,
   input  logic              sii_mon_ready,
   input  logic [1:0]        sii_mon_eot
);
   localparam int W_COL = $clog2(IMG_W);
   localparam int W_ROW = $clog2(IMG_H);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

   state_t            r_state, w_next;
   logic [W_COL-1:0]  r_col;
   logic [W_ROW-1:0]  r_row;
   logic              r_ii_done, r_sii_done, r_frame_done;
   logic [W_FCNT-1:0] r_frame_cnt;
   logic              w_beat, w_col_last, w_row_last, w_launch;
   logic              w_ii_hit, w_sii_hit, w_finish;

   assign w_col_last = (r_col == W_COL'(IMG_W - 1));
   assign w_row_last = (r_row == W_ROW'(IMG_H - 1));
   assign w_beat     = gen_valid && gen_ready;
   assign w_launch   = (r_state == S_IDLE) && start;
   assign w_ii_hit   = ii_mon_valid && ii_mon_ready && (ii_mon_eot == 2'b11);
   assign w_sii_hit  = sii_mon_valid && sii_mon_ready && (sii_mon_eot == 2'b11);
   // A handshake landing in the same cycle counts as already done.
   assign w_finish   = (r_state == S_DRAIN) && (r_ii_done || w_ii_hit) && (r_sii_done || w_sii_hit);

   always_ff @(posedge clk)
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = start ? S_STREAM : S_IDLE;
         S_STREAM: w_next = (w_beat && gen_eot == 2'b11) ? S_DRAIN : S_STREAM;
         S_DRAIN:  w_next = w_finish ? S_IDLE : S_DRAIN;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state != S_IDLE);
      gen_valid  = (r_state == S_STREAM) && pix_valid;
      pix_ready  = (r_state == S_STREAM) && gen_ready;
      gen_data   = pix_data;
      gen_eot[0] = w_col_last;
      gen_eot[1] = w_col_last && w_row_last;
      frame_done = r_frame_done;
      frame_cnt  = r_frame_cnt;
   end

   always_ff @(posedge clk)
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_launch) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_beat) begin
         r_col <= w_col_last ? '0 : r_col + 1'b1;
         if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
      end

   always_ff @(posedge clk)
      if (!rst) begin
         r_ii_done  <= 1'b0;
         r_sii_done <= 1'b0;
      end else if (w_launch) begin
         r_ii_done  <= 1'b0;
         r_sii_done <= 1'b0;
      end else if (r_state != S_IDLE) begin
         if (w_ii_hit)  r_ii_done  <= 1'b1;
         if (w_sii_hit) r_sii_done <= 1'b1;
      end

   always_ff @(posedge clk)
      if (!rst) begin
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_frame_done <= w_finish;
         if (w_finish) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
endmodule

// File: tb/tb_ii_frame_ctrl.sv
// tb_ii_frame_ctrl: randomized frame traffic for ii_frame_ctrl on a 4x3 image,
// checked against a beat-index model of row/frame end flags and frame completion.
module tb_ii_frame_ctrl;
   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy, frame_done, pix_ready, gen_valid;
   logic [15:0] frame_cnt;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = '0;
   logic        gen_ready = 1'b0;
   logic [7:0]  gen_data;
   logic [1:0]  gen_eot;
   logic        ii_mon_valid = 1'b0, ii_mon_ready = 1'b0;
   logic [1:0]  ii_mon_eot = 2'b00;
   logic        sii_mon_valid = 1'b0, sii_mon_ready = 1'b0;
   logic [1:0]  sii_mon_eot = 2'b00;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;

   ii_frame_ctrl #(.W_DATA(8), .IMG_W(W), .IMG_H(H), .W_FCNT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_data(gen_data), .gen_eot(gen_eot),
      .ii_mon_valid(ii_mon_valid), .ii_mon_ready(ii_mon_ready), .ii_mon_eot(ii_mon_eot),
      .sii_mon_valid(sii_mon_valid), .sii_mon_ready(sii_mon_ready), .sii_mon_eot(sii_mon_eot)
   );

   always #5 clk = ~clk;

   // k-th beat of a frame (0-based): row end on every W-th, frame end on the last.
   function automatic logic [1:0] exp_eot(input int k);
      int c, r;
      c = k % W;
      r = (k / W) % H;
      return (c != W - 1) ? 2'b00 : (r == H - 1) ? 2'b11 : 2'b01;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string name, input logic e_busy, input logic e_done);
      checks++;
      if (busy !== e_busy || frame_done !== e_done || frame_cnt !== exp_cnt[15:0]) begin
         failures++;
         $display("FAIL %s: busy=%b done=%b cnt=%0d, required busy=%b done=%b cnt=%0d",
                  name, busy, frame_done, frame_cnt, e_busy, e_done, exp_cnt);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_status("start_busy", 1'b1, 1'b0);
   endtask

   // Streams n beats starting at frame beat index k0; rdy_pct sets the downstream ready rate.
   task automatic stream(input int n, input int k0, input int rdy_pct, input bit start_mid);
      int k, sent, cyc;
      logic [7:0] d;
      k = k0; sent = 0; cyc = 0;
      d = 8'($urandom);
      pix_data = d;
      pix_valid = 1'b1;
      while (sent < n && cyc < 2000) begin
         gen_ready = ($urandom_range(99) < rdy_pct);
         if (start_mid && sent == n / 2) start = 1'b1;
         @(negedge clk);
         checks++;
         if (gen_valid !== pix_valid || pix_ready !== gen_ready || (gen_valid && gen_data !== d)) begin
            failures++;
            $display("FAIL pass_through: gv=%b pr=%b gd=%h, required gv=%b pr=%b gd=%h",
                     gen_valid, pix_ready, gen_data, pix_valid, gen_ready, d);
         end
         checks++;
         if (gen_eot !== exp_eot(k)) begin
            failures++;
            $display("FAIL eot_beat%0d: got %b, required %b", k + 1, gen_eot, exp_eot(k));
         end
         if (gen_valid && gen_ready) begin
            k++;
            sent++;
         end
         tick();
         start = 1'b0;
         if (pix_valid && gen_ready) begin
            d = 8'($urandom);
            pix_data = d;
            pix_valid = ($urandom_range(99) < 80);
         end else if (!pix_valid) pix_valid = ($urandom_range(99) < 80);
         cyc++;
      end
      if (cyc >= 2000) begin
         failures++;
         $display("FAIL stream_timeout: sent %0d, required %0d", sent, n);
      end
      pix_valid = 1'b0;
      gen_ready = 1'b0;
   endtask

   task automatic mon_beat(input bit ii, input bit sii, input logic [1:0] eot, input logic rdy);
      ii_mon_valid = ii; ii_mon_ready = ii & rdy; ii_mon_eot = eot;
      sii_mon_valid = sii; sii_mon_ready = sii & rdy; sii_mon_eot = eot;
      tick();
      ii_mon_valid = 1'b0; ii_mon_ready = 1'b0; ii_mon_eot = 2'b00;
      sii_mon_valid = 1'b0; sii_mon_ready = 1'b0; sii_mon_eot = 2'b00;
   endtask

   task automatic check_drain_blocks;
      pix_valid = 1'b1;
      gen_ready = 1'b1;
      pix_data = 8'hA5;
      @(negedge clk);
      checks++;
      if (pix_ready !== 1'b0 || gen_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_block: pix_ready=%b gen_valid=%b, required 0 0", pix_ready, gen_valid);
      end
      tick();
      pix_valid = 1'b0;
      gen_ready = 1'b0;
   endtask

   // sii finishes lead cycles before ii (0 = same cycle); b2b starts the next frame at frame_done.
   task automatic finish_frame(input int lead, input bit b2b);
      if (lead == 0) mon_beat(1'b1, 1'b1, 2'b11, 1'b1);
      else begin
         mon_beat(1'b0, 1'b1, 2'b11, 1'b1);
         for (int i = 1; i < lead; i++) begin
            check_status("drain_wait", 1'b1, 1'b0);
            tick();
         end
         check_status("drain_wait", 1'b1, 1'b0);
         mon_beat(1'b1, 1'b0, 2'b11, 1'b1);
      end
      exp_cnt++;
      check_status("frame_done", 1'b0, 1'b1);
      if (b2b) pulse_start();
      else begin
         tick();
         check_status("done_pulse_end", 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      pix_valid = 1'b1;
      gen_ready = 1'b1;
      start = 1'b1;
      repeat (3) tick();
      check_status("reset_status", 1'b0, 1'b0);
      checks++;
      if (gen_valid !== 1'b0 || pix_ready !== 1'b0 || gen_eot !== 2'b00) begin
         failures++;
         $display("FAIL reset_stream: gv=%b pr=%b eot=%b, required 0 0 00", gen_valid, pix_ready, gen_eot);
      end
      start = 1'b0;
      pix_valid = 1'b0;
      gen_ready = 1'b0;
      rst = 1'b1;
      tick();
      check_status("idle_after_reset", 1'b0, 1'b0);
   endtask

   task automatic test_single_frame;
      pulse_start();
      stream(N, 0, 100, 1'b0);
      for (int i = 0; i < 30; i++) begin
         check_status("drain_hold", 1'b1, 1'b0);
         tick();
      end
      finish_frame(0, 1'b0);
   endtask

   task automatic test_backpressure;
      pulse_start();
      stream(N, 0, 50, 1'b0);
      check_drain_blocks();
      finish_frame(5, 1'b0);
   endtask

   task automatic test_back_to_back;
      pulse_start();
      stream(N, 0, 70, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_status("start_in_drain", 1'b1, 1'b0);
      mon_beat(1'b1, 1'b1, 2'b01, 1'b1);
      check_status("spurious_eot01", 1'b1, 1'b0);
      mon_beat(1'b1, 1'b1, 2'b11, 1'b0);
      check_status("no_ready_eot11", 1'b1, 1'b0);
      finish_frame(2, 1'b1);
      stream(N, 0, 60, 1'b0);
      finish_frame(0, 1'b0);
   endtask

   task automatic test_reset_mid;
      pulse_start();
      stream(6, 0, 100, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      check_status("mid_reset", 1'b0, 1'b0);
      pix_valid = 1'b1;
      gen_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (gen_valid !== 1'b0 || pix_ready !== 1'b0 || gen_eot !== 2'b00) begin
         failures++;
         $display("FAIL mid_reset_stream: gv=%b pr=%b eot=%b, required 0 0 00", gen_valid, pix_ready, gen_eot);
      end
      tick();
      pulse_start();
      stream(N, 0, 80, 1'b0);
      finish_frame(1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
